sd_clk_drp_ctrl: RTL and testbench
==================================

// Module: sd_clk_drp_ctrl
// PURPOSE
//  Sequencer that reprograms the SD-card clock wizard (clk_wiz1) CLKOUT0 divider through its DRP port.
//  Accepts a divide request from the SD host logic and holds the MMCM in reset.
//  Read-modify-writes ClkReg1/ClkReg2, then releases reset and waits for sd_clk_locked.
//  Sits between the SD controller and the clk_wiz1 DRP/reset/locked pins; sole DRP master.
// PARAMETERS
//  ADDR_REG1     7'h08  DRP address of CLKOUT0 ClkReg1 (high[11:6], low[5:0])
//  ADDR_REG2     7'h09  DRP address of CLKOUT0 ClkReg2 (edge[7], no_count[6])
//  RST_HOLD      4      cycles clk_wiz1_rst held high before first DRP access
//  DRDY_TIMEOUT  255    max cycles waiting for sd_clk_drdy per access
//  LOCK_TIMEOUT  65535  max cycles waiting for sd_clk_locked after reset release
// PORTS
//  clk            in   1   system clock (DRP clock)
//  rstn           in   1   async active-low reset
//  req_valid      in   1   divide request valid
//  req_ready      out  1   high only in IDLE; transfer = req_valid & req_ready
//  req_div        in   8   requested CLKOUT0 divide (1..255)
//  busy           out  1   high in every state except IDLE
//  done           out  1   1-cycle pulse: reprogram complete and locked
//  err            out  1   1-cycle pulse: rejected request or timeout
//  sd_clk_daddr   out  7   DRP address
//  sd_clk_den     out  1   DRP enable, 1-cycle pulse per access
//  sd_clk_dwe     out  1   DRP write enable, only with den
//  sd_clk_din     out  16  DRP write data
//  sd_clk_dout    in   16  DRP read data, valid with drdy
//  sd_clk_drdy    in   1   DRP access complete
//  clk_wiz1_rst   out  1   MMCM reset, active high
//  sd_clk_locked  in   1   MMCM lock indicator
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; state IDLE; counters 0. Async reset mid-sequence aborts at once.
//   No completion pulse follows the abort; DRP state of the MMCM is left as-is.
//  Divide coding, captured at accept:
//   div==1: high=1, low=1, no_count=1, edge=0.
//   Otherwise: high=div>>1, low=div-high, edge=div[0], no_count=0.
//  New data:
//   REG1 = {rd[15:12], high[5:0], low[5:0]}.
//   REG2 = {rd[15:8], edge, no_count, rd[5:0]}.
//  req_div==0: accept, err pulse next cycle, no DRP traffic, clk_wiz1_rst untouched, back to IDLE.
//  FSM:
//   IDLE: on accept -> RST; clk_wiz1_rst=1.
//   RST: count RST_HOLD cycles -> RD(REG1).
//   RD: den=1, dwe=0, daddr=ADDR for 1 cycle -> RD_W.
//   RD_W: on drdy, latch dout -> WR.
//   WR: den=1, dwe=1, din=merged data for 1 cycle -> WR_W.
//   WR_W: on drdy -> RD(REG2) after REG1, or REL after REG2.
//   REL: clk_wiz1_rst=0 -> LOCK.
//   LOCK: on sd_clk_locked -> DONE.
//   DONE: done=1 for 1 cycle -> IDLE.
//  Timeouts: wait counter cleared on entering RD_W/WR_W/LOCK.
//   Reaching DRDY_TIMEOUT or LOCK_TIMEOUT -> ERR.
//   ERR: err=1 for 1 cycle, clk_wiz1_rst=0 -> IDLE.
//  drdy is ignored outside RD_W/WR_W; drdy in the same cycle as den is not possible per DRP and need not be handled.
//  daddr/din hold their values until the next access. den never asserts twice without an intervening drdy or timeout.
//  req_valid while busy is not accepted (req_ready=0); req_div is sampled only at accept.
//  sd_clk_locked already high on entering LOCK is accepted that cycle; it must first be seen after REL.
// TESTING
//  1 div=10, REG1 rd 0xF000, REG2 rd 0x0300, drdy 2 cycles after den:
//    -> writes 0xF145 to 0x08, 0x0300 to 0x09; done pulses 1 cycle after locked.
//  2 div=7, REG1 rd 0x0000, REG2 rd 0x00FF:
//    -> writes 0x00C4 to 0x08, 0x00BF to 0x09 (edge=1, no_count=0).
//  3 div=1 -> REG1 write 0x0041; REG2 bit6=1, bit7=0.
//  4 div=0 -> err pulse, den never asserts, clk_wiz1_rst stays 0, req_ready back high in 2 cycles.
//  5 drdy withheld on REG2 read -> err after 255 wait cycles, clk_wiz1_rst=0, IDLE.
//  6 rstn low during WR_W -> all outputs to reset values immediately; new request after reset completes normally.
//    Also held off: req_valid while busy is ignored.

Source files
------------

// File: rtl/sd_clk_drp_ctrl.sv
// sd_clk_drp_ctrl
//   Reprograms the clk_wiz1 CLKOUT0 divider over DRP. A divide request
//   puts the MMCM into reset. ClkReg1 and then ClkReg2 are each read,
//   merged with the new divide fields and written back. The MMCM is then
//   released from reset, and the block waits for lock.
// Ports
//   clk, rstn        DRP clock, async active-low reset
//   req_valid/ready  request handshake, req_div = divide value (1..255)
//   busy/done/err    status; done and err are single-cycle pulses
//   sd_clk_*         DRP master (daddr/den/dwe/din out, dout/drdy in)
//   clk_wiz1_rst     MMCM reset (active high); sd_clk_locked = MMCM lock
module sd_clk_drp_ctrl #(
  parameter logic [6:0] ADDR_REG1    = 7'h08,
  parameter logic [6:0] ADDR_REG2    = 7'h09,
  parameter int         RST_HOLD     = 4,
  parameter int         DRDY_TIMEOUT = 255,
  parameter int         LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_div,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  sd_clk_daddr,
  output logic        sd_clk_den,
  output logic        sd_clk_dwe,
  output logic [15:0] sd_clk_din,
  input  logic [15:0] sd_clk_dout,
  input  logic        sd_clk_drdy,
  output logic        clk_wiz1_rst,
  input  logic        sd_clk_locked
);

  localparam logic [3:0] S_IDLE = 4'd0, S_RST  = 4'd1, S_RD   = 4'd2, S_RD_W = 4'd3,
                         S_WR   = 4'd4, S_WR_W = 4'd5, S_REL  = 4'd6, S_LOCK = 4'd7,
                         S_DONE = 4'd8, S_ERR  = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        reg2_q, reg2_d;      // 0: working on ClkReg1, 1: ClkReg2
  logic [5:0]  high_q, high_d, low_q, low_d;
  logic        edge_q, edge_d, nocnt_q, nocnt_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] din_q, din_d;
  logic        mrst_q, mrst_d;

  // dout[7:6] is overwritten in ClkReg2 and lies in the replaced field of ClkReg1.
  logic unused_dout;
  assign unused_dout = ^sd_clk_dout[7:6];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg2_d  = reg2_q;
    high_d  = high_q;
    low_d   = low_q;
    edge_d  = edge_q;
    nocnt_d = nocnt_q;
    daddr_d = daddr_q;
    din_d   = din_q;
    mrst_d  = mrst_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        if (req_div == 8'd0) begin
          state_d = S_ERR;
        end else begin
          state_d = S_RST;
          cnt_d   = '0;
          reg2_d  = 1'b0;
          mrst_d  = 1'b1;
          if (req_div == 8'd1) begin
            // Divide-by-1 bypasses the counter entirely.
            high_d  = 6'd1;
            low_d   = 6'd1;
            edge_d  = 1'b0;
            nocnt_d = 1'b1;
          end else begin
            high_d  = 6'(req_div >> 1);
            low_d   = 6'(req_div - (req_div >> 1));
            edge_d  = req_div[0];
            nocnt_d = 1'b0;
          end
        end
      end
      S_RST: begin
        if (cnt_q == 16'(RST_HOLD - 1)) begin
          state_d = S_RD;
          daddr_d = ADDR_REG1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD: begin
        state_d = S_RD_W;
        cnt_d   = '0;
      end
      S_RD_W: begin
        if (sd_clk_drdy) begin
          state_d = S_WR;
          din_d   = reg2_q ? {sd_clk_dout[15:8], edge_q, nocnt_q, sd_clk_dout[5:0]}
                           : {sd_clk_dout[15:12], high_q, low_q};
        end else if (cnt_q == 16'(DRDY_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WR: begin
        state_d = S_WR_W;
        cnt_d   = '0;
      end
      S_WR_W: begin
        if (sd_clk_drdy) begin
          if (reg2_q) begin
            state_d = S_REL;
            mrst_d  = 1'b0;
          end else begin
            state_d = S_RD;
            reg2_d  = 1'b1;
            daddr_d = ADDR_REG2;
          end
        end else if (cnt_q == 16'(DRDY_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_REL: begin
        state_d = S_LOCK;
        cnt_d   = '0;
      end
      S_LOCK: begin
        if (sd_clk_locked) begin
          state_d = S_DONE;
        end else if (cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;   // S_DONE, S_ERR: one-cycle pulse states
    endcase
    // Any error path leaves the MMCM out of reset.
    if (state_d == S_ERR) mrst_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      reg2_q  <= 1'b0;
      high_q  <= '0;
      low_q   <= '0;
      edge_q  <= 1'b0;
      nocnt_q <= 1'b0;
      daddr_q <= '0;
      din_q   <= '0;
      mrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg2_q  <= reg2_d;
      high_q  <= high_d;
      low_q   <= low_d;
      edge_q  <= edge_d;
      nocnt_q <= nocnt_d;
      daddr_q <= daddr_d;
      din_q   <= din_d;
      mrst_q  <= mrst_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign sd_clk_den   = (state_q == S_RD) || (state_q == S_WR);
  assign sd_clk_dwe   = (state_q == S_WR);
  assign sd_clk_daddr = daddr_q;
  assign sd_clk_din   = din_q;
  assign clk_wiz1_rst = mrst_q;

endmodule

// File: tb/tb_sd_clk_drp_ctrl.sv
// Bench for sd_clk_drp_ctrl: a DRP slave and MMCM lock model, a write
// monitor, and a divide-field reference model built from plain arithmetic.
module tb_sd_clk_drp_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_div = 8'd0;
  logic        req_ready, busy, done, err;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] din;
  logic [15:0] dout = 16'd0;
  logic        drdy = 1'b0;
  logic        mrst;
  logic        locked = 1'b0;

  always #5 clk = ~clk;

  sd_clk_drp_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_div(req_div),
    .busy(busy), .done(done), .err(err),
    .sd_clk_daddr(daddr), .sd_clk_den(den), .sd_clk_dwe(dwe), .sd_clk_din(din),
    .sd_clk_dout(dout), .sd_clk_drdy(drdy),
    .clk_wiz1_rst(mrst), .sd_clk_locked(locked)
  );

  int checks = 0;
  int failures = 0;

  // Environment knobs, written only by the initial block.
  logic [15:0] mem1 = 16'd0, mem2 = 16'd0;
  int lat = 2, lock_lat = 5;
  bit block_rd2 = 1'b0;

  // Monitor state, written only by the always blocks.
  int cyc = 0;
  int den_n = 0, wr_n = 0, done_n = 0, err_n = 0, rsthi_n = 0, den_rstlo_n = 0;
  int last_den_cyc = 0, lock_rise_cyc = 0;
  logic [6:0]  wa [0:63];
  logic [15:0] wd [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (den) begin
      den_n <= den_n + 1;
      last_den_cyc <= cyc;
      if (!mrst) den_rstlo_n <= den_rstlo_n + 1;
      if (dwe) begin
        wa[wr_n[5:0]] <= daddr;
        wd[wr_n[5:0]] <= din;
        wr_n <= wr_n + 1;
      end
    end
    if (done) done_n <= done_n + 1;
    if (err)  err_n  <= err_n + 1;
    if (mrst) rsthi_n <= rsthi_n + 1;
  end

  // DRP slave: drdy after 'lat' cycles, reads return mem1/mem2.
  int lcnt = 0;
  bit pend = 1'b0, pwe = 1'b0;
  logic [6:0] paddr = 7'd0;
  always @(negedge clk) begin
    drdy <= 1'b0;
    if (den) begin
      pend <= 1'b1; lcnt <= lat; paddr <= daddr; pwe <= dwe;
    end else if (pend) begin
      if (lcnt > 1) lcnt <= lcnt - 1;
      else if (!(block_rd2 && !pwe && paddr == 7'h09)) begin
        drdy <= 1'b1;
        pend <= 1'b0;
        dout <= (paddr == 7'h08) ? mem1 : mem2;
      end
    end
  end

  // MMCM lock: drops while in reset, returns lock_lat cycles after release.
  int lkc = 0;
  always @(negedge clk) begin
    if (mrst) begin
      lkc <= 0; locked <= 1'b0;
    end else if (lkc < lock_lat) begin
      lkc <= lkc + 1;
    end else if (!locked) begin
      locked <= 1'b1; lock_rise_cyc <= cyc;
    end
  end

  // Reference: expected register images from the divide rules.
  task automatic model(input int d, input logic [15:0] r1, input logic [15:0] r2,
                       output logic [15:0] e1, output logic [15:0] e2);
    int h, l, ed, nc;
    if (d == 1) begin h = 1; l = 1; ed = 0; nc = 1; end
    else begin h = d / 2; l = d - h; ed = d % 2; nc = 0; end
    e1 = 16'((int'(r1) / 4096) * 4096 + (h % 64) * 64 + (l % 64));
    e2 = 16'((int'(r2) / 256) * 256 + ed * 128 + nc * 64 + (int'(r2) % 64));
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++;
    if ({busy, done, err, den, dwe, mrst} !== 6'b0 || daddr !== 7'd0 || din !== 16'd0) begin
      failures++; $display("FAIL reset_outs got=%b daddr=%h din=%h exp=0", {busy, done, err, den, dwe, mrst}, daddr, din);
    end
    rstn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_prog(input string nm, input logic [7:0] d, input logic [15:0] r1,
                           input logic [15:0] r2, input int l, input int ll, input bit hold_off);
    int w0, d0, k0;
    bit seen;
    logic [15:0] x1, x2;
    mem1 = r1; mem2 = r2; lat = l; lock_lat = ll;
    model(int'(d), r1, r2, x1, x2);
    w0 = wr_n; d0 = done_n; k0 = den_rstlo_n;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL %s ready_idle got=%b exp=1", nm, req_ready); end
    req_valid = 1'b1; req_div = d;
    @(negedge clk);
    if (hold_off) begin
      req_div = ~d;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL %s held_off ready=%b busy=%b exp ready=0 busy=1", nm, req_ready, busy);
      end
    end
    req_valid = 1'b0; req_div = 8'd0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    checks++; if (!seen || done !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL %s completion seen=%b done=%b err=%b exp done=1 err=0", nm, seen, done, err);
    end
    checks++; if (cyc - lock_rise_cyc !== 1) begin
      failures++; $display("FAIL %s done_after_lock got=%0d exp=1", nm, cyc - lock_rise_cyc);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || req_ready !== 1'b1 || mrst !== 1'b0 || done_n - d0 !== 1) begin
      failures++; $display("FAIL %s after_done done=%b ready=%b rst=%b pulses=%0d exp 0/1/0/1", nm, done, req_ready, mrst, done_n - d0);
    end
    checks++; if (wr_n - w0 !== 2) begin
      failures++; $display("FAIL %s write_count got=%0d exp=2", nm, wr_n - w0);
    end else begin
      checks++; if (wa[w0[5:0]] !== 7'h08 || wd[w0[5:0]] !== x1) begin
        failures++; $display("FAIL %s reg1_write got=%h:%h exp=08:%h", nm, wa[w0[5:0]], wd[w0[5:0]], x1);
      end
      checks++; if (wa[6'(w0 + 1)] !== 7'h09 || wd[6'(w0 + 1)] !== x2) begin
        failures++; $display("FAIL %s reg2_write got=%h:%h exp=09:%h", nm, wa[6'(w0 + 1)], wd[6'(w0 + 1)], x2);
      end
    end
    checks++; if (den_rstlo_n - k0 !== 0) begin
      failures++; $display("FAIL %s den_without_rst got=%0d exp=0", nm, den_rstlo_n - k0);
    end
  endtask

  task automatic test_reject();
    int n0, r0, e0;
    n0 = den_n; r0 = rsthi_n; e0 = err_n;
    @(negedge clk); req_valid = 1'b1; req_div = 8'd0;
    @(negedge clk); req_valid = 1'b0;
    checks++; if (err !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL reject_err err=%b ready=%b exp err=1 ready=0", err, req_ready);
    end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL reject_ready ready=%b err=%b exp ready=1 err=0", req_ready, err);
    end
    @(negedge clk);
    checks++; if (den_n - n0 !== 0 || rsthi_n - r0 !== 0 || err_n - e0 !== 1) begin
      failures++; $display("FAIL reject_side den=%0d rst_cycles=%0d errs=%0d exp 0/0/1", den_n - n0, rsthi_n - r0, err_n - e0);
    end
  endtask

  task automatic test_timeout();
    int w0, d0;
    bit seen;
    w0 = wr_n; d0 = done_n;
    block_rd2 = 1'b1; lat = 2; mem1 = 16'(($urandom)); mem2 = 16'(($urandom));
    @(negedge clk); req_valid = 1'b1; req_div = 8'($urandom_range(2, 255));
    @(negedge clk); req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (err || done) seen = 1'b1;
    end
    checks++; if (!seen || err !== 1'b1) begin
      failures++; $display("FAIL timeout_err seen=%b err=%b exp=1", seen, err);
    end
    checks++; if (cyc - last_den_cyc !== 256) begin
      failures++; $display("FAIL timeout_len got=%0d exp=256", cyc - last_den_cyc);
    end
    checks++; if (mrst !== 1'b0) begin failures++; $display("FAIL timeout_rst got=%b exp=0", mrst); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || wr_n - w0 !== 1 || done_n - d0 !== 0) begin
      failures++; $display("FAIL timeout_after ready=%b writes=%0d dones=%0d exp 1/1/0", req_ready, wr_n - w0, done_n - d0);
    end
    block_rd2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int d0;
    bit seen;
    d0 = done_n;
    lat = 10; mem1 = 16'h1234; mem2 = 16'h5678;
    @(negedge clk); req_valid = 1'b1; req_div = 8'd20;
    @(negedge clk); req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (den && dwe) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL abort_reach_wr seen=0 exp=1"); end
    @(negedge clk);   // now waiting for write drdy
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || {busy, done, err, den, dwe, mrst} !== 6'b0 || daddr !== 7'd0 || din !== 16'd0) begin
      failures++; $display("FAIL abort_outs ready=%b flags=%b daddr=%h din=%h exp ready=1 rest=0",
                           req_ready, {busy, done, err, den, dwe, mrst}, daddr, din);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (done_n - d0 !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_n - d0); end
    test_prog("after_abort", 8'd12, 16'hABCD, 16'h4321, 2, 6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_prog("div10", 8'd10, 16'hF000, 16'h0300, 2, 5, 1'b0);
    test_prog("div7",  8'd7,  16'h0000, 16'h00FF, 2, 5, 1'b0);
    test_prog("div1",  8'd1,  16'h0000, 16'h0000, 1, 3, 1'b0);
    test_reject();
    test_timeout();
    test_async_reset();
    test_prog("held_off", 8'd33, 16'h5A5A, 16'hC3C3, 3, 8, 1'b1);
    for (int n = 0; n < 10; n++) begin
      test_prog("rand", 8'($urandom_range(1, 255)), 16'($urandom), 16'($urandom),
                int'($urandom_range(1, 5)), int'($urandom_range(1, 30)), 1'b0);
    end
    test_prog("div255", 8'd255, 16'hFFFF, 16'hFFFF, 2, 4, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
